decoder: RTL

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 64 ++++++
 rtl/decoder_decode_logic.sv | 101 ++++++++++
 rtl/decoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the RV32 decode stage: fetch/decode payloads, format enum,
// major opcode constants and the per-format immediate builder.
// Optional RV32M decode is selected by defining RV32M_EN (consumed by decode_logic).
package decoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetcher_output;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    fmt_e        fmt;
    logic        illegal;
    logic        is_m;
  } decoder_output;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Sign-extended immediate for a given format; R-type carries no immediate.
  function automatic logic [31:0] imm_for(input fmt_e fmt, input logic [31:0] i);
    logic [31:0] r;
    case (fmt)
      FMT_I:   r = {{20{i[31]}}, i[31:20]};
      FMT_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   r = {i[31:12], 12'b0};
      FMT_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decoder_decode_logic.sv
// Pure combinational RV32I (+ optional RV32M via RV32M_EN) instruction decode.
// Latency: 0 cycles. No handshake; the caller registers the result.
// Illegal encodings still produce a record (fmt=R, imm=0, illegal=1).
module decode_logic
  import decoder_pkg::*;
(
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  output decoder_output dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Classify the opcode, check funct fields, then build fields by format.
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.opcode  = opc;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.fmt     = FMT_R;
    dec.illegal = 1'b1;
    dec.is_m    = 1'b0;

    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt     = FMT_U;
        dec.illegal = 1'b0;
      end
      OPC_JAL: begin
        dec.fmt     = FMT_J;
        dec.illegal = 1'b0;
      end
      OPC_JALR: begin
        dec.fmt     = FMT_I;
        dec.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.fmt     = FMT_B;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.fmt     = FMT_I;
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.fmt     = FMT_S;
        dec.illegal = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        dec.fmt = FMT_I;
        // Shift-immediates encode the shift type in funct7.
        if (f3 == 3'b001)      dec.illegal = (f7 != F7_BASE);
        else if (f3 == 3'b101) dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        else                   dec.illegal = 1'b0;
      end
      OPC_OP: begin
        dec.fmt = FMT_R;
        if (f7 == F7_BASE)     dec.illegal = 1'b0;
        else if (f7 == F7_ALT) dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
`ifdef RV32M_EN
        else if (f7 == F7_MULDIV) begin
          dec.illegal = 1'b0;
          dec.is_m    = 1'b1;
        end
`endif
        else                   dec.illegal = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.fmt     = FMT_I;
        dec.illegal = (f3 != 3'b000);
      end
      default: ;
    endcase

    // Illegal records carry no format-specific decode.
    if (dec.illegal) dec.fmt = FMT_R;

    case (dec.fmt)
      FMT_U, FMT_J: begin
        dec.rs1 = 5'd0;
        dec.rs2 = 5'd0;
      end
      FMT_S, FMT_B: dec.rd  = 5'd0;
      FMT_I:        dec.rs2 = 5'd0;
      default: ;
    endcase

    dec.imm = imm_for(dec.fmt, instr);
  end

endmodule

// File: rtl/decoder.sv
// Decode stage: registered output plus one skid slot between fetch and execute.
// Latency: 1 cycle accept-to-output. decoder_ready is a flop (state != TWO),
// independent of executor_ready. Optional RV32M decode via RV32M_EN.
module decoder
  import decoder_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          fetcher_valid,
  input  fetcher_output fetcher_out,
  output logic          decoder_ready,
  output logic          decoder_valid,
  output decoder_output decoder_out,
  input  logic          executor_ready,
  input  logic          flush
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]    state_q, state_d;
  decoder_output out_q, out_d;
  decoder_output skid_q, skid_d;
  logic          ready_q, ready_d;
  decoder_output dec_w;
  logic          accept;
  logic          consume;

  decode_logic u_decode (
    .pc    (fetcher_out.pc),
    .instr (fetcher_out.instr),
    .dec   (dec_w)
  );

  // Flush blocks acceptance; consume only when something is presented.
  assign accept  = fetcher_valid && ready_q && !flush;
  assign consume = (state_q != ST_EMPTY) && executor_ready;

  // Next-state for the output/skid pair; flush empties both.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = dec_w;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, consume})
            2'b10: begin
              skid_d  = dec_w;
              state_d = ST_TWO;
            end
            2'b01: begin
              out_d   = '0;
              state_d = ST_EMPTY;
            end
            2'b11: out_d = dec_w;
            default: ;
          endcase
        end
        ST_TWO: begin
          if (consume) begin
            out_d   = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          out_d   = '0;
          skid_d  = '0;
        end
      endcase
    end
    ready_d = (state_d != ST_TWO);
  end

  // State and data registers; reset holds everything empty with ready low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign decoder_ready = ready_q;
  assign decoder_valid = (state_q != ST_EMPTY);
  assign decoder_out   = out_q;

endmodule
